// File: rtl/msg_pkg.sv
// Shared constants, stored message table and window-index helper for the message scroller.
package msg_pkg;

  localparam int unsigned TBL_CHAR_W = 8;
  localparam int unsigned TBL_LEN    = 16;
  localparam int unsigned TBL_MSGS   = 4;

  localparam logic [TBL_CHAR_W-1:0] CHAR_SPACE = 8'h20;

  typedef logic [TBL_CHAR_W-1:0] char_t;

  // Message 0 is "''_HELLO_CLIP.''"; messages 1..3 are letter, digit and greeting banners padded with spaces.
  localparam char_t MSG_TABLE [TBL_MSGS][TBL_LEN] = '{
    '{8'h27, 8'h27, 8'h20, 8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F,
      8'h20, 8'h43, 8'h4C, 8'h49, 8'h50, 8'h2E, 8'h27, 8'h27},
    '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48,
      8'h49, 8'h4A, 8'h4B, 8'h4C, 8'h4D, 8'h4E, 8'h4F, 8'h50},
    '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
      8'h38, 8'h39, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20},
    '{8'h48, 8'h49, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20,
      8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20}
  };

  // Wrapped character index for display slot k; k never exceeds len, so one subtract suffices.
  function automatic int unsigned win_idx(int unsigned pos, int unsigned k, int unsigned len);
    int unsigned sum;
    sum = pos + k;
    if (sum >= len) sum = sum - len;
    return sum;
  endfunction

endpackage

// File: rtl/msg_rom.sv
// Constant message table with NUM_DISP independent combinational read ports.
module msg_rom
  import msg_pkg::*;
#(
  parameter int unsigned CHAR_W   = 8,
  parameter int unsigned NUM_DISP = 6,
  parameter int unsigned POS_W    = 4,
  parameter int unsigned SEL_W    = 2
) (
  input  logic [SEL_W-1:0]                 msg,
  input  logic [NUM_DISP-1:0][POS_W-1:0]   idx,
  output logic [NUM_DISP-1:0][CHAR_W-1:0]  chars
);

  localparam int unsigned TM_W = (TBL_MSGS > 1) ? $clog2(TBL_MSGS) : 1;
  localparam int unsigned TL_W = (TBL_LEN > 1) ? $clog2(TBL_LEN) : 1;

  logic msg_ok_c;

  // Anything outside the stored table reads as a blank.
  always_comb begin
    msg_ok_c = (32'(msg) < TBL_MSGS);
    for (int unsigned k = 0; k < NUM_DISP; k++) begin
      chars[k] = CHAR_W'(CHAR_SPACE);
      if (msg_ok_c && (32'(idx[k]) < TBL_LEN)) begin
        chars[k] = CHAR_W'(MSG_TABLE[TM_W'(msg)][TL_W'(idx[k])]);
      end
    end
  end

endmodule

// File: rtl/message_scroller.sv
// Scrolling window over stored messages: prescaled tick, bidirectional wrap-around position,
// deferred message switching at the wrap point and a registered multi-character display.
module message_scroller
  import msg_pkg::*;
#(
  parameter  int unsigned CHAR_W   = 8,
  parameter  int unsigned MSG_LEN  = 16,
  parameter  int unsigned NUM_MSGS = 4,
  parameter  int unsigned NUM_DISP = 6,
  parameter  int unsigned TICK_DIV = 25000000,
  localparam int unsigned POS_W    = $clog2(MSG_LEN),
  localparam int unsigned SEL_W    = (NUM_MSGS > 1) ? $clog2(NUM_MSGS) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic                         dir,
  input  logic                         load,
  input  logic [SEL_W-1:0]             msg_sel,
  output logic [NUM_DISP*CHAR_W-1:0]   display,
  output logic [POS_W-1:0]             pos,
  output logic                         wrap
);

  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PRE_W-1:0]                 prescaler;
  logic [SEL_W-1:0]                 act_msg;
  logic [SEL_W-1:0]                 pend_msg;
  logic                             pend_vld;

  logic                             tick_c;
  logic                             wrap_tick_c;
  logic                             sel_ok_c;
  logic [POS_W-1:0]                 pos_next_c;
  logic [NUM_DISP-1:0][POS_W-1:0]   rd_idx_c;
  logic [NUM_DISP-1:0][CHAR_W-1:0]  rd_chars_c;
  logic [NUM_DISP*CHAR_W-1:0]       disp_next_c;

  // Tick, next position and wrap detection for the current direction.
  always_comb begin
    tick_c      = en && (prescaler == PRE_W'(TICK_DIV - 1));
    sel_ok_c    = (32'(msg_sel) < NUM_MSGS);
    wrap_tick_c = 1'b0;
    pos_next_c  = pos;
    if (dir) begin
      pos_next_c  = (pos == '0) ? POS_W'(MSG_LEN - 1) : pos - POS_W'(1);
      wrap_tick_c = tick_c && (pos == '0);
    end else begin
      pos_next_c  = (pos == POS_W'(MSG_LEN - 1)) ? '0 : pos + POS_W'(1);
      wrap_tick_c = tick_c && (pos == POS_W'(MSG_LEN - 1));
    end
  end

  // Window read addresses follow the registered position, so the display trails pos by one cycle.
  always_comb begin
    for (int unsigned k = 0; k < NUM_DISP; k++) begin
      rd_idx_c[k] = POS_W'(win_idx(32'(pos), k, MSG_LEN));
    end
  end

  msg_rom #(
    .CHAR_W   (CHAR_W),
    .NUM_DISP (NUM_DISP),
    .POS_W    (POS_W),
    .SEL_W    (SEL_W)
  ) u_rom (
    .msg   (act_msg),
    .idx   (rd_idx_c),
    .chars (rd_chars_c)
  );

  // Slot 0 is the leftmost character and occupies the most significant byte.
  always_comb begin
    disp_next_c = '0;
    for (int unsigned k = 0; k < NUM_DISP; k++) begin
      disp_next_c[(NUM_DISP-1-k)*CHAR_W +: CHAR_W] = rd_chars_c[k];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prescaler <= '0;
      pos       <= '0;
      act_msg   <= '0;
      pend_msg  <= '0;
      pend_vld  <= 1'b0;
      wrap      <= 1'b0;
      display   <= {NUM_DISP{CHAR_W'(CHAR_SPACE)}};
    end else begin
      display <= disp_next_c;
      wrap    <= 1'b0;
      if (load) begin
        // Load restarts the scroll even while frozen and suppresses any coincident wrap.
        prescaler <= '0;
        pos       <= '0;
        pend_vld  <= 1'b0;
        if (sel_ok_c) act_msg <= msg_sel;
      end else if (en) begin
        prescaler <= tick_c ? '0 : prescaler + PRE_W'(1);
        if (tick_c) pos <= pos_next_c;
        wrap <= wrap_tick_c;
        // A requested message only takes over at the wrap so the current pass is never cut short.
        if (wrap_tick_c && pend_vld) begin
          act_msg  <= pend_msg;
          pend_vld <= 1'b0;
        end else if (sel_ok_c) begin
          pend_msg <= msg_sel;
          pend_vld <= (msg_sel != act_msg);
        end
      end
    end
  end

endmodule

// File: tb/tb_message_scroller.sv
// Directed plus randomized bench for message_scroller against an arithmetic reference model.
module tb_message_scroller;

  localparam int TICK_DIV = 4;
  localparam int MSG_LEN  = 16;
  localparam int NUM_MSGS = 3;
  localparam int NUM_DISP = 6;
  localparam int CHAR_W   = 8;
  localparam logic [47:0] BLANK = 48'h202020202020;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        dir;
  logic        load;
  logic [1:0]  msg_sel;
  logic [47:0] display;
  logic [3:0]  pos;
  logic        wrap;

  message_scroller #(
    .CHAR_W   (CHAR_W),
    .MSG_LEN  (MSG_LEN),
    .NUM_MSGS (NUM_MSGS),
    .NUM_DISP (NUM_DISP),
    .TICK_DIV (TICK_DIV)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .dir     (dir),
    .load    (load),
    .msg_sel (msg_sel),
    .display (display),
    .pos     (pos),
    .wrap    (wrap)
  );

  always #5 clk = ~clk;

  logic [7:0]  tbl [4][16];
  int          m_pos, m_pres, m_act, m_pend, m_dpos;
  logic        m_wrap;
  logic [47:0] exp_disp;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [47:0] window(int m, int p);
    logic [47:0] r;
    int c;
    r = '0;
    for (int k = 0; k < NUM_DISP; k++) begin
      c = (p + k) % MSG_LEN;
      r[(NUM_DISP-1-k)*8 +: 8] = tbl[m[1:0]][c[3:0]];
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pos = 0; m_pres = 0; m_act = 0; m_pend = -1; m_dpos = 0;
    m_wrap = 1'b0; exp_disp = BLANK;
  endtask

  task automatic model_edge();
    int  s;
    bit  tick, wraps;
    s = int'(msg_sel);
    exp_disp = window(m_act, m_pos);
    m_dpos = m_pos;
    m_wrap = 1'b0;
    if (load) begin
      m_pres = 0; m_pos = 0; m_pend = -1;
      if (s < NUM_MSGS) m_act = s;
    end else if (en) begin
      tick   = (m_pres == TICK_DIV - 1);
      m_pres = tick ? 0 : m_pres + 1;
      wraps  = tick && (dir ? (m_pos == 0) : (m_pos == MSG_LEN - 1));
      if (tick) m_pos = dir ? (m_pos + MSG_LEN - 1) % MSG_LEN : (m_pos + 1) % MSG_LEN;
      m_wrap = wraps;
      if (wraps && m_pend >= 0) begin
        m_act = m_pend; m_pend = -1;
      end else if (s < NUM_MSGS) begin
        m_pend = (s != m_act) ? s : -1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("pos", 48'(pos), 48'(m_pos));
    chk("wrap", 48'(wrap), 48'(m_wrap));
    chk("display", display, exp_disp);
  endtask

  task automatic wait_pos(input int p, input int pr, input string tag);
    int n;
    n = 0;
    while (!(m_pos == p && (pr < 0 || m_pres == pr)) && n < 300) begin
      step();
      n++;
    end
    checks++;
    assert (n < 300) else begin
      errors++;
      $error("FAIL %s timeout observed=%0d expected=<300 cycles", tag, n);
    end
  endtask

  task automatic wait_wrap(input string tag);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!m_wrap && n < 300);
    checks++;
    assert (n < 300) else begin
      errors++;
      $error("FAIL %s timeout observed=%0d expected=<300 cycles", tag, n);
    end
  endtask

  initial begin
    int  wraps;
    bit  seen13;
    tbl = '{
      '{8'h27, 8'h27, 8'h20, 8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F,
        8'h20, 8'h43, 8'h4C, 8'h49, 8'h50, 8'h2E, 8'h27, 8'h27},
      '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48,
        8'h49, 8'h4A, 8'h4B, 8'h4C, 8'h4D, 8'h4E, 8'h4F, 8'h50},
      '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
        8'h38, 8'h39, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20},
      '{8'h48, 8'h49, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20,
        8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20}
    };
    reset = 1'b0; en = 1'b0; dir = 1'b0; load = 1'b0; msg_sel = 2'd0;
    model_reset();

    // Reset state, then first valid window one clock after release.
    #23;
    chk("rst_display", display, BLANK);
    chk("rst_pos", 48'(pos), 48'd0);
    chk("rst_wrap", 48'(wrap), 48'd0);
    @(negedge clk);
    reset = 1'b1;
    step();
    chk("first_window", display, 48'h27272048454C);

    // Forward scroll through one full pass.
    en = 1'b1; dir = 1'b0; wraps = 0; seen13 = 1'b0;
    for (int i = 0; i < 16 * TICK_DIV; i++) begin
      step();
      if (wrap) wraps++;
      if (m_dpos == 13 && !seen13) begin
        seen13 = 1'b1;
        chk("win_pos13", display, 48'h2E2727272720);
      end
    end
    chk("fwd_wrap_count", 48'(wraps), 48'd1);

    // Reverse from position 0.
    dir = 1'b1;
    repeat (TICK_DIV) step();
    chk("rev_pos15", 48'(pos), 48'd15);
    chk("rev_wrap", 48'(wrap), 48'd1);
    repeat (TICK_DIV) step();
    step();
    chk("win_pos14", display, 48'h272727272048);

    // Deferred message switch and out-of-range select.
    dir = 1'b0;
    wait_pos(5, -1, "reach_pos5");
    msg_sel = 2'd1;
    wait_wrap("switch_wrap");
    step();
    chk("msg1_window", display, 48'h414243444546);
    msg_sel = 2'd3;
    wait_wrap("oor_wrap");
    step();
    chk("oor_ignored", display, 48'h414243444546);

    // Load while frozen mid-prescale.
    wait_pos(9, 2, "reach_pos9");
    en = 1'b0; load = 1'b1; msg_sel = 2'd2;
    step();
    chk("load_pos", 48'(pos), 48'd0);
    load = 1'b0;
    step();
    chk("load_window", display, 48'h303132333435);
    en = 1'b1;
    repeat (TICK_DIV - 1) step();
    chk("load_presc_hold", 48'(pos), 48'd0);
    step();
    chk("load_presc_tick", 48'(pos), 48'd1);

    // Load coinciding with a wrapping tick.
    wait_pos(15, TICK_DIV - 1, "reach_pos15");
    load = 1'b1; msg_sel = 2'd0;
    step();
    chk("load_wrap_suppr", 48'(wrap), 48'd0);
    chk("load_wrap_pos", 48'(pos), 48'd0);
    load = 1'b0;

    // Randomized control mix against the model.
    for (int i = 0; i < 400; i++) begin
      en      = ($urandom_range(0, 9) < 7);
      dir     = 1'($urandom_range(0, 1));
      load    = ($urandom_range(0, 29) == 0);
      msg_sel = 2'($urandom_range(0, 3));
      step();
    end
    load = 1'b0; en = 1'b1; dir = 1'b0; msg_sel = 2'd0;

    // Asynchronous reset between edges, then a frozen interval.
    wait_pos(7, -1, "reach_pos7");
    #2;
    reset = 1'b0;
    #1;
    chk("async_pos", 48'(pos), 48'd0);
    chk("async_wrap", 48'(wrap), 48'd0);
    chk("async_display", display, BLANK);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    en = 1'b0;
    repeat (20) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
